aes_selftest_seq: RTL

Parametrised self-test sequencer for the AES encrypt/decrypt cores, generalising the fixed 256-bit round-trip wrapper to all key sizes and to multiple test vectors. It walks a vector table, drives one external cipher core through encrypt and decrypt requests via a start/done handshake, and compares both results. It accumulates pass/fail counts and a watchdog timeout flag, then raises checkOut. Sits between a vector ROM and the cipher core at the top of the AES test datapath.

---
 rtl/aes_selftest_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_selftest_seq.sv
// AES self-test sequencer: walks a vector table, drives one cipher core through
// an encrypt and a decrypt round trip per vector, and tallies pass/fail results.
module aes_selftest_seq #(
  parameter int unsigned KEY_BITS    = 256,
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned TIMEOUT     = 1023,
  localparam int unsigned IDX_W      = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [IDX_W-1:0]    vec_idx,
  input  logic [KEY_BITS-1:0] vec_key,
  input  logic [127:0]        vec_pt,
  input  logic [127:0]        vec_ct,
  output logic [KEY_BITS-1:0] core_key,
  output logic [127:0]        core_din,
  output logic                core_mode,
  output logic                core_start,
  input  logic                core_done,
  input  logic [127:0]        core_dout,
  output logic                busy,
  output logic                done,
  output logic                checkOut,
  output logic [IDX_W:0]      pass_cnt,
  output logic [IDX_W:0]      fail_cnt,
  output logic [IDX_W-1:0]    first_fail_idx,
  output logic                timeout_err
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_ENC_REQ  = 3'd2;
  localparam logic [2:0] S_ENC_WAIT = 3'd3;
  localparam logic [2:0] S_DEC_REQ  = 3'd4;
  localparam logic [2:0] S_DEC_WAIT = 3'd5;
  localparam logic [2:0] S_NEXT     = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  // Reject unsupported configurations at elaboration
  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
    $error("aes_selftest_seq: KEY_BITS must be 128, 192 or 256");
  end
  if (NUM_VECTORS < 1) begin : g_bad_nv
    $error("aes_selftest_seq: NUM_VECTORS must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("aes_selftest_seq: TIMEOUT must be at least 1");
  end

  logic [2:0]          r_state,    w_nxt;
  logic [IDX_W-1:0]    r_idx,      w_idx;
  logic [127:0]        r_pt,       w_pt;
  logic [127:0]        r_ct,       w_ct;
  logic                r_pass,     w_pass;
  logic [WD_W-1:0]     r_wdog,     w_wdog;
  logic [KEY_BITS-1:0] r_core_key, w_core_key;
  logic [127:0]        r_core_din, w_core_din;
  logic                r_mode,     w_mode;
  logic                r_start,    w_start;
  logic                r_busy,     w_busy;
  logic                r_done,     w_done;
  logic                r_check,    w_check;
  logic [CNT_W-1:0]    r_pcnt,     w_pcnt;
  logic [CNT_W-1:0]    r_fcnt,     w_fcnt;
  logic [IDX_W-1:0]    r_ffi,      w_ffi;
  logic                r_tmo,      w_tmo;
  logic                w_wd_exp;

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_nxt      = r_state;
    w_idx      = r_idx;
    w_pt       = r_pt;
    w_ct       = r_ct;
    w_pass     = r_pass;
    w_wdog     = r_wdog;
    w_core_key = r_core_key;
    w_core_din = r_core_din;
    w_mode     = r_mode;
    w_pcnt     = r_pcnt;
    w_fcnt     = r_fcnt;
    w_ffi      = r_ffi;
    w_tmo      = r_tmo;
    w_wd_exp   = (r_wdog == WD_W'(TIMEOUT - 1));

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_nxt  = S_LOAD;
          w_idx  = '0;
          w_pcnt = '0;
          w_fcnt = '0;
          w_ffi  = '0;
          w_tmo  = 1'b0;
        end
      end
      S_LOAD: begin
        w_pt       = vec_pt;
        w_ct       = vec_ct;
        w_pass     = 1'b1;
        w_core_key = vec_key;
        w_core_din = vec_pt;
        w_mode     = 1'b0;
        w_nxt      = S_ENC_REQ;
      end
      S_ENC_REQ: begin
        w_wdog = '0;
        w_nxt  = S_ENC_WAIT;
      end
      S_ENC_WAIT: begin
        // A done coincident with watchdog expiry counts as a normal completion
        if (core_done) begin
          if (core_dout != r_ct) w_pass = 1'b0;
          w_core_din = r_ct;
          w_mode     = 1'b1;
          w_nxt      = S_DEC_REQ;
        end else if (w_wd_exp) begin
          w_pass = 1'b0;
          w_tmo  = 1'b1;
          w_nxt  = S_NEXT;
        end else begin
          w_wdog = r_wdog + WD_W'(1);
        end
      end
      S_DEC_REQ: begin
        w_wdog = '0;
        w_nxt  = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        if (core_done) begin
          if (core_dout != r_pt) w_pass = 1'b0;
          w_nxt = S_NEXT;
        end else if (w_wd_exp) begin
          w_pass = 1'b0;
          w_tmo  = 1'b1;
          w_nxt  = S_NEXT;
        end else begin
          w_wdog = r_wdog + WD_W'(1);
        end
      end
      S_NEXT: begin
        if (r_pass) begin
          w_pcnt = r_pcnt + CNT_W'(1);
        end else begin
          w_fcnt = r_fcnt + CNT_W'(1);
          if (r_fcnt == '0) w_ffi = r_idx;
        end
        if (r_idx == IDX_W'(NUM_VECTORS - 1)) begin
          w_nxt = S_DONE;
        end else begin
          w_idx = r_idx + IDX_W'(1);
          w_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        if (!enable) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase

    w_start = (w_nxt == S_ENC_REQ) || (w_nxt == S_DEC_REQ);
    w_busy  = (w_nxt != S_IDLE) && (w_nxt != S_DONE);
    w_done  = (w_nxt == S_DONE);
    w_check = (w_nxt == S_DONE) && (w_fcnt == '0);
  end

  // State and output registers; reset aborts any run in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_pt       <= '0;
      r_ct       <= '0;
      r_pass     <= 1'b0;
      r_wdog     <= '0;
      r_core_key <= '0;
      r_core_din <= '0;
      r_mode     <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_check    <= 1'b0;
      r_pcnt     <= '0;
      r_fcnt     <= '0;
      r_ffi      <= '0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_idx      <= w_idx;
      r_pt       <= w_pt;
      r_ct       <= w_ct;
      r_pass     <= w_pass;
      r_wdog     <= w_wdog;
      r_core_key <= w_core_key;
      r_core_din <= w_core_din;
      r_mode     <= w_mode;
      r_start    <= w_start;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_check    <= w_check;
      r_pcnt     <= w_pcnt;
      r_fcnt     <= w_fcnt;
      r_ffi      <= w_ffi;
      r_tmo      <= w_tmo;
    end
  end

  assign vec_idx        = r_idx;
  assign core_key       = r_core_key;
  assign core_din       = r_core_din;
  assign core_mode      = r_mode;
  assign core_start     = r_start;
  assign busy           = r_busy;
  assign done           = r_done;
  assign checkOut       = r_check;
  assign pass_cnt       = r_pcnt;
  assign fail_cnt       = r_fcnt;
  assign first_fail_idx = r_ffi;
  assign timeout_err    = r_tmo;

endmodule
